// File: rtl/arb8_mx_pkg.sv
// Shared definitions for the arb8_mx round-robin channel arbiter.
//   state_e  : FSM encoding (IDLE / GRANT)
//   pick_t   : result of a round-robin scan (found flag + winner index)
//   rr_pick  : circular first-set-bit search starting at a pointer
package arb8_mx_pkg;

  localparam int NREQ         = 8;
  localparam int SELW         = 3;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // Scans ptr, ptr+1, ... mod NREQ. Walking offsets from high to low lets the
  // smallest offset (closest to ptr) overwrite the result last and win.
  function automatic pick_t rr_pick(input logic [SELW-1:0] ptr,
                                    input logic [NREQ-1:0] req);
    pick_t           p;
    logic [SELW-1:0] idx;
    p.found = 1'b0;
    p.idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = ptr + SELW'(k);
      if (req[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/arb8_mx_if.sv
// Requester/channel bundle for arb8_mx.
//   req  : per-requester request lines
//   d    : per-requester data bits into the shared 8:1 channel
//   gnt  : one-hot registered grant
//   sel  : registered winner index (mux select)
//   busy : a grant is active
//   y    : channel output, gated by busy
interface arb8_mx_if;
  import arb8_mx_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] d;
  logic [NREQ-1:0] gnt;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            y;

  modport master (output req, d, input gnt, sel, busy, y);
  modport slave  (input req, d, output gnt, sel, busy, y);
endinterface

// File: rtl/arb8_mx_mx8.sv
// 8:1 bit multiplexer built as a three-level tree of 2:1 muxes.
//   mx2 : a,b data, s select, y = s ? b : a
//   mx8 : a..h data (index 0..7), s2,s1,s0 select (s2 is MSB), y output
module mx2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = s ? b : a;
endmodule

module mx8 (
  input  logic a, b, c, d, e, f, g, h,
  input  logic s2, s1, s0,
  output logic y
);
  logic m0, m1, m2, m3, n0, n1;

  mx2 u_m0 (.a(a),  .b(b),  .s(s0), .y(m0));
  mx2 u_m1 (.a(c),  .b(d),  .s(s0), .y(m1));
  mx2 u_m2 (.a(e),  .b(f),  .s(s0), .y(m2));
  mx2 u_m3 (.a(g),  .b(h),  .s(s0), .y(m3));
  mx2 u_n0 (.a(m0), .b(m1), .s(s1), .y(n0));
  mx2 u_n1 (.a(m2), .b(m3), .s(s1), .y(n1));
  mx2 u_o  (.a(n0), .b(n1), .s(s2), .y(y));
endmodule

// File: rtl/arb8_mx.sv
// Round-robin arbiter sharing one 8:1 bit channel among 8 requesters.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : arb8_mx_if.slave (req, d in; gnt, sel, busy, y out)
// A grant lasts until its requester drops req or MAX_HOLD cycles elapse;
// at release the pointer moves past the holder and a new winner is loaded
// on the same edge, so back-to-back grants have no idle bubble.
module arb8_mx
  import arb8_mx_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF,
  parameter int CW       = 3
) (
  input  logic      clk,
  input  logic      reset,
  arb8_mx_if.slave  bus
);

  state_e          state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            busy_q, busy_d;

  logic [SELW-1:0] arb_ptr;
  pick_t           pick;
  logic            rel;
  logic            mx_y;

  // In GRANT the only time the pick matters is at release, where the
  // pointer has already advanced past the holder; one picker serves both.
  assign arb_ptr = (state_q == GRANT) ? (sel_q + SELW'(1)) : ptr_q;
  assign pick    = rr_pick(arb_ptr, bus.req);
  assign rel     = !bus.req[sel_q] || (cnt_q == CW'(MAX_HOLD - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << pick.idx;
          sel_d   = pick.idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          ptr_d = arb_ptr;
          if (pick.found) begin
            gnt_d = NREQ'(1) << pick.idx;
            sel_d = pick.idx;
            cnt_d = '0;
          end else begin
            // sel keeps its last value while idle
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  mx8 u_mx8 (
    .a (bus.d[0]), .b (bus.d[1]), .c (bus.d[2]), .d (bus.d[3]),
    .e (bus.d[4]), .f (bus.d[5]), .g (bus.d[6]), .h (bus.d[7]),
    .s2(sel_q[2]), .s1(sel_q[1]), .s0(sel_q[0]),
    .y (mx_y)
  );

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.y    = busy_q & mx_y;

endmodule
